alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational ALU instance between two requesters (e.g. the execute stage and an address/branch helper). Each requester issues an operation through a valid/ready handshake. The block arbitrates round-robin, registers the operands, drives the shared ALU, captures the result, and returns it on a per-requester response handshake. Only one operation is in flight at a time.

## Interface

Parameters:
- W, 32, operand/result width; the ALU port widths match.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op1, req0_op2 / req1_op1, req1_op2  in  W  operands
- req0_aluop / req1_aluop  in  4  ALU selector
- alu_op1, alu_op2  out  W  to shared ALU Op1/Op2
- alu_aluop  out  4  to shared ALU AluOp
- alu_res  in  W  from shared ALU Res (combinational)
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp_res  out  W  result, shared by both response channels
- rsp_illegal  out  1  captured op was not a supported code
- busy  out  1  state != IDLE

## Operation

- FSM states: IDLE, EXEC, RESP. Owner register `own` (0/1) and priority bit `prio` (0/1).
- IDLE:
  - Grant: if only one reqN_valid, grant N. If both, grant `prio`.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. Combinational; at most one ready high.
  - On handshake: capture op1/op2/aluop into alu_op1/alu_op2/alu_aluop registers, set own=N, go EXEC.
- EXEC (one cycle):
  - ALU sees the registered operands.
  - Capture alu_res into rsp_res.
  - rsp_illegal = aluop not in {0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned GT}. No filtering; rsp_res is whatever the ALU returns (0 for illegal codes).
  - Go RESP.
- RESP:
  - rsp{own}_valid = 1; the other rsp_valid = 0.
  - rsp_res and rsp_illegal are held stable.
  - When rsp{own}_ready = 1: prio = ~own, go IDLE.
  - rspN_ready of the non-owner is ignored.
- alu_* registers keep their last value outside handshakes; they change only on a request capture.
- Requesters must hold valid and data stable until ready. The block does not check this.
- Reset values: state=IDLE, prio=0, own=0, alu_op1=alu_op2=0, alu_aluop=0000, rsp_res=0, rsp_illegal=0, rsp0/1_valid=0, busy=0.
  - req0/1_ready=0 whenever both valids are low. This includes directly after reset.

## Timing

- Request handshake at cycle N edge. EXEC in cycle N+1. rsp_valid first high in cycle N+2.
- Minimum latency 2 cycles from acceptance to response valid.
- Peak throughput: 1 op / 3 cycles (accept, exec, respond with rsp_ready=1).
- Back-pressure: RESP lasts until rsp_ready. No new request is accepted meanwhile; both req_ready stay 0.
- Simultaneous valids: the priority requester wins. Fairness: after serving N, the other requester wins the next contention.
- A request arriving while busy waits; it is not lost, because valid is held.
- Asynchronous reset mid-operation (any state): all registers return to reset values immediately.
  - In-flight op is discarded; no response is produced.
  - prio returns to 0.
- Arithmetic/width rules belong to the ALU; this block adds no width conversion. alu_res is sampled only in EXEC.

## Test plan

- Single ADD: req0 op1=5, op2=3, aluop=0010, rsp0_ready=1.
  - Expect req0_ready at N, rsp0_valid at N+2 with rsp_res=8, rsp_illegal=0, rsp1_valid=0.
- Contention and fairness:
  - req0 SUB 10-4 and req1 OR 0xF0|0x0F, both valid from reset. Expect req0 served first (6), then req1 (0xFF).
  - Repeat both. Expect order req1 then req0.
- Back-pressure: req1 GT 7>2 with rsp1_ready held 0 for 4 cycles.
  - Expect rsp1_valid high and rsp_res=1 stable all 4 cycles.
  - Expect req0_ready=0 throughout, even with req0_valid=1. Completion 1 cycle after rsp1_ready rises.
- Illegal op: req0 aluop=1111, op1=op2=0xFFFFFFFF. Expect rsp_res=0, rsp_illegal=1.
  - The following legal AND op returns rsp_illegal=0.
- Reset mid-op: assert rst_n=0 during EXEC.
  - Expect all outputs at reset values within the same cycle and no rsp_valid afterward.
  - Next request completes normally with prio=0.
- Back-to-back: req0 holds valid across three AND ops. Expect acceptances 3 cycles apart with rsp0_ready=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. One operation in flight at a time: accept (IDLE), execute
// (EXEC), respond (RESP). Operands and results are held in registers.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_op1,
  input  logic [W-1:0] req0_op2,
  input  logic [3:0]   req0_aluop,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_op1,
  input  logic [W-1:0] req1_op2,
  input  logic [3:0]   req1_aluop,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [3:0]   alu_aluop,
  input  logic [W-1:0] alu_res,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_illegal,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   own;
  logic   prio;
  logic   grant;
  logic   own_ready;

  // Only the five codes the shared ALU implements are considered legal.
  function automatic logic is_illegal(input logic [3:0] op);
    logic ill;
    case (op)
      4'b0000: ill = 1'b0;  // AND
      4'b0001: ill = 1'b0;  // OR
      4'b0010: ill = 1'b0;  // ADD
      4'b0110: ill = 1'b0;  // SUB
      4'b0111: ill = 1'b0;  // unsigned GT
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Pick the requester to serve: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Handshake only in IDLE; grant guarantees at most one ready is high.
  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && (grant == 1'b0);
    req1_ready = (state == IDLE) && req1_valid && (grant == 1'b1);
  end

  // Response consumed by the owning requester; the other ready is ignored.
  always_comb begin
    own_ready = 1'b0;
    if (own == 1'b1) begin
      own_ready = rsp1_ready;
    end else begin
      own_ready = rsp0_ready;
    end
  end

  // Main FSM with all registered outputs: capture, execute, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      own         <= 1'b0;
      prio        <= 1'b0;
      alu_op1     <= {W{1'b0}};
      alu_op2     <= {W{1'b0}};
      alu_aluop   <= 4'b0000;
      rsp_res     <= {W{1'b0}};
      rsp_illegal <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_op1   <= req0_op1;
            alu_op2   <= req0_op2;
            alu_aluop <= req0_aluop;
            own       <= 1'b0;
            busy      <= 1'b1;
            state     <= EXEC;
          end else if (req1_ready) begin
            alu_op1   <= req1_op1;
            alu_op2   <= req1_op2;
            alu_aluop <= req1_aluop;
            own       <= 1'b1;
            busy      <= 1'b1;
            state     <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          // The ALU is combinational on the registered operands.
          rsp_res     <= alu_res;
          rsp_illegal <= is_illegal(alu_aluop);
          rsp0_valid  <= ~own;
          rsp1_valid  <= own;
          state       <= RESP;
        end
        RESP: begin
          if (own_ready) begin
            prio       <= ~own;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A behavioural ALU drives alu_res;
// expected results are hand-computed constants.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]   req0_aluop, req1_aluop;
  logic [W-1:0] alu_op1, alu_op2, alu_res;
  logic [3:0]   alu_aluop;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_res;
  logic         rsp_illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc0, acc1, acc2;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_aluop(req1_aluop),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
    .alu_res(alu_res),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency/throughput measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model.
  always_comb begin
    alu_res = '0;
    case (alu_aluop)
      4'b0000: alu_res = alu_op1 & alu_op2;
      4'b0001: alu_res = alu_op1 | alu_op2;
      4'b0010: alu_res = alu_op1 + alu_op2;
      4'b0110: alu_res = alu_op1 - alu_op2;
      4'b0111: alu_res = {31'd0, (alu_op1 > alu_op2)};
      default: alu_res = '0;
    endcase
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serve one already-presented request of requester 'who' from IDLE to IDLE.
  task automatic serve(input string tag, input int who, input logic drop,
                       input logic [W-1:0] exp_res, input logic exp_ill, output int acc);
    #1;
    chk({tag, "_rdy"}, (who == 0) ? req0_ready : req1_ready, 1);
    chk({tag, "_rdy_other"}, (who == 0) ? req1_ready : req0_ready, 0);
    acc = cyc;
    tick();  // accept edge; now EXEC
    if (drop) begin
      if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
    #1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_exec_rdy"}, {req0_ready, req1_ready}, 0);
    chk({tag, "_exec_rspv"}, {rsp0_valid, rsp1_valid}, 0);
    tick();  // EXEC edge; now RESP
    chk({tag, "_rspv"}, {rsp0_valid, rsp1_valid}, (who == 0) ? 2'b10 : 2'b01);
    chk({tag, "_res"}, rsp_res, exp_res);
    chk({tag, "_ill"}, rsp_illegal, exp_ill);
    if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();  // completion edge; now IDLE
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_rspv"}, {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_aluop = 4'b0000;
    req1_op1 = '0; req1_op2 = '0; req1_aluop = 4'b0000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_rspv", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_res", rsp_res, 0);
    chk("rst_ill", rsp_illegal, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_aluop", alu_aluop, 0);
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", {req0_ready, req1_ready}, 0);

    // Contention: req0 SUB 10-4 vs req1 OR F0|0F; req0 keeps a second SUB pending.
    req0_op1 = 32'd10; req0_op2 = 32'd4; req0_aluop = 4'b0110; req0_valid = 1'b1;
    req1_op1 = 32'hF0; req1_op2 = 32'h0F; req1_aluop = 4'b0001; req1_valid = 1'b1;
    serve("cont_a0", 0, 1'b0, 32'd6, 1'b0, acc0);
    chk("cont_a0_opcap", alu_aluop, 4'b0110);
    // Both valid again, prio now 1: req1 first, then req0.
    serve("cont_b1", 1, 1'b1, 32'hFF, 1'b0, acc0);
    serve("cont_b0", 0, 1'b1, 32'd6, 1'b0, acc0);

    // Single ADD with latency measurement.
    req0_op1 = 32'd5; req0_op2 = 32'd3; req0_aluop = 4'b0010; req0_valid = 1'b1;
    #1;
    chk("add_rdy", req0_ready, 1);
    acc0 = cyc;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("add_lat", cyc - acc0, 2);
    chk("add_rspv", {rsp0_valid, rsp1_valid}, 2'b10);
    chk("add_res", rsp_res, 32'd8);
    chk("add_ill", rsp_illegal, 0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;  // non-owner ready ignored
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk("add_done", busy, 0);

    // Back-pressure: req1 GT 7>2, rsp1_ready low for 4 cycles, req0 waiting.
    req1_op1 = 32'd7; req1_op2 = 32'd2; req1_aluop = 4'b0111; req1_valid = 1'b1;
    #1;
    chk("bp_rdy", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_op1 = 32'hFF00FF00; req0_op2 = 32'h0FF00FF0; req0_aluop = 4'b0000; req0_valid = 1'b1;
    tick();  // RESP
    for (int i = 0; i < 4; i++) begin
      chk("bp_rspv", rsp1_valid, 1);
      chk("bp_res", rsp_res, 32'd1);
      chk("bp_req0_rdy", req0_ready, 0);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp_hold_rspv", rsp1_valid, 1);
    tick();
    rsp1_ready = 1'b0;
    chk("bp_done_rspv", rsp1_valid, 0);
    chk("bp_done_busy", busy, 0);
    serve("bp_wait0", 0, 1'b1, 32'h0F000F00, 1'b0, acc0);

    // Illegal op, then a legal AND clears the flag.
    req0_op1 = 32'hFFFFFFFF; req0_op2 = 32'hFFFFFFFF; req0_aluop = 4'b1111; req0_valid = 1'b1;
    serve("ill", 0, 1'b1, 32'd0, 1'b1, acc0);
    req0_op1 = 32'h0000F0F0; req0_op2 = 32'h0000FF00; req0_aluop = 4'b0000; req0_valid = 1'b1;
    serve("ill_and", 0, 1'b1, 32'h0000F000, 1'b0, acc0);

    // Reset during EXEC of a req1 op (last served was req0, so prio is 1).
    req1_op1 = 32'd1; req1_op2 = 32'd2; req1_aluop = 4'b0001; req1_valid = 1'b1;
    #1;
    chk("mr_rdy", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rspv", {rsp0_valid, rsp1_valid}, 0);
    chk("mr_op1", alu_op1, 0);
    chk("mr_aluop", alu_aluop, 0);
    chk("mr_res", rsp_res, 0);
    chk("mr_rdy0", {req0_ready, req1_ready}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    end
    // prio back to 0: contention goes to req0.
    req0_op1 = 32'd1; req0_op2 = 32'd1; req0_aluop = 4'b0010; req0_valid = 1'b1;
    req1_valid = 1'b1;
    serve("mr_p0", 0, 1'b1, 32'd2, 1'b0, acc0);
    serve("mr_p1", 1, 1'b1, 32'd3, 1'b0, acc0);

    // Back-to-back: req0 holds valid across three AND ops.
    req0_op1 = 32'h0000AAAA; req0_op2 = 32'h000000FF; req0_aluop = 4'b0000; req0_valid = 1'b1;
    serve("b2b_0", 0, 1'b0, 32'h000000AA, 1'b0, acc0);
    serve("b2b_1", 0, 1'b0, 32'h000000AA, 1'b0, acc1);
    serve("b2b_2", 0, 1'b1, 32'h000000AA, 1'b0, acc2);
    chk("b2b_gap01", acc1 - acc0, 3);
    chk("b2b_gap12", acc2 - acc1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
